// File: rtl/aes_pkg.sv
// Shared AES types, round constants, S-box and scheduler FSM states.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;

  typedef logic [7:0]       byte_t;
  typedef logic [3:0][7:0]  word_t;
  typedef logic [15:0][7:0] block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Entry 0 is unused; round r uses RCON[r].
  localparam byte_t RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t rcon_of(input logic [3:0] round);
    byte_t rc;
    rc = '0;
    for (int unsigned i = 0; i <= 10; i++) begin
      if (round == 4'(i)) rc = RCON[i];
    end
    return rc;
  endfunction

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  function automatic byte_t sbox(input byte_t a);
    byte_t sq;
    byte_t inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational single-round AES-128 key expansion step.
module aes_key_round
  import aes_pkg::*;
(
  input  block_t prev_key,
  input  byte_t  rcon,
  output block_t next_key_c
);

  word_t w0, w1, w2, w3;
  word_t t;
  word_t n0, n1, n2, n3;

  always_comb begin
    w0 = prev_key[15:12];
    w1 = prev_key[11:8];
    w2 = prev_key[7:4];
    w3 = prev_key[3:0];
    // SubWord(RotWord(w3)) with the round constant folded into the top byte.
    t  = {sbox(w3[2]) ^ rcon, sbox(w3[1]), sbox(w3[0]), sbox(w3[3])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key_c = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 round-key scheduler with indexed registered read port.
// Optional AES_KEYSCHED_BULK_EN exposes rounds 1..NUM_ROUNDS flattened on rk_all.
module aes_key_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  block_t       key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output block_t       rk_out,
  output logic         rk_valid,
  output logic         rk_err
`ifdef AES_KEYSCHED_BULK_EN
  ,
  output logic [16*NUM_ROUNDS-1:0][7:0] rk_all
`endif
);

  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
  localparam int unsigned IDX_W    = 4;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] round_q;
  logic [IDX_W-1:0] prev_idx;
  block_t           slot_q [NUM_KEYS];
  block_t           prev_key, next_key, rd_key;
  byte_t            rcon;
  logic             accept, last_round, rd_ok;

  assign last_round = (round_q == IDX_W'(NUM_ROUNDS));
  assign prev_idx   = round_q - IDX_W'(1);
  assign rcon       = rcon_of(round_q);
  assign rd_ok      = rk_req && keys_valid && (rk_idx <= IDX_W'(NUM_ROUNDS));

  // Slot muxes written as compare loops so no index can fall outside the file.
  always_comb begin
    prev_key = '0;
    rd_key   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (prev_idx == IDX_W'(i)) prev_key = slot_q[i];
      if (rk_idx == IDX_W'(i))   rd_key   = slot_q[i];
    end
  end

  aes_key_round u_round (
    .prev_key   (prev_key),
    .rcon       (rcon),
    .next_key_c (next_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE, READY: begin
        key_ready = 1'b1;
        if (key_valid) begin
          accept  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (last_round) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key storage and round counter; keys_valid only rises on the final round write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q    <= '0;
      keys_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) slot_q[i] <= '0;
    end else if (accept) begin
      slot_q[0]  <= key_in;
      round_q    <= IDX_W'(1);
      keys_valid <= 1'b0;
    end else if (state_q == EXPAND) begin
      for (int unsigned i = 1; i < NUM_KEYS; i++) begin
        if (round_q == IDX_W'(i)) slot_q[i] <= next_key;
      end
      if (last_round) begin
        round_q    <= '0;
        keys_valid <= 1'b1;
      end else begin
        round_q <= round_q + IDX_W'(1);
      end
    end
  end

  // Read port; rejected requests leave rk_out holding its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out   <= '0;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
    end else begin
      rk_valid <= rd_ok;
      rk_err   <= rk_req && !rd_ok;
      if (rd_ok) rk_out <= rd_key;
    end
  end

`ifdef AES_KEYSCHED_BULK_EN
  always_comb begin
    rk_all = '0;
    for (int unsigned r = 1; r <= NUM_ROUNDS; r++) begin
      rk_all[16*(r-1) +: 16] = slot_q[r];
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Scoreboard bench for aes_key_scheduler using FIPS-197 and all-zero key vectors.
module tb_aes_key_scheduler;
  import aes_pkg::*;

  localparam block_t K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t F_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam block_t F_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam block_t F_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam block_t K_ZERO  = 128'h0;
  localparam block_t Z_R1    = 128'h62636363626363636263636362636363;
  localparam block_t Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam block_t K_JUNK  = 128'hffeeddccbbaa99887766554433221100;

  typedef struct packed {
    logic   v;
    logic   e;
    block_t d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  block_t     key_in;
  logic       key_valid;
  logic       key_ready;
  logic       busy;
  logic       keys_valid;
  logic       rk_req;
  logic [3:0] rk_idx;
  block_t     rk_out;
  logic       rk_valid;
  logic       rk_err;
`ifdef AES_KEYSCHED_BULK_EN
  logic [16*NUM_ROUNDS-1:0][7:0] rk_all;
`endif

  int     pass_cnt  = 0;
  int     total_cnt = 0;
  exp_t   sb [$];
  block_t model_out;

  always #5 clk = ~clk;

  aes_key_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_err     (rk_err)
`ifdef AES_KEYSCHED_BULK_EN
    ,
    .rk_all     (rk_all)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkb(input string name, input block_t act, input block_t exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one read at the current negedge; the expected response goes to the scoreboard.
  task automatic rd(input logic [3:0] idx, input logic ok, input block_t d);
    exp_t e;
    rk_req = 1'b1;
    rk_idx = idx;
    if (ok) model_out = d;
    e.v = ok;
    e.e = !ok;
    e.d = model_out;
    sb.push_back(e);
    @(negedge clk);
    rk_req = 1'b0;
  endtask

  task automatic load(input block_t k);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_keys(input string name);
    int n;
    n = 0;
    while (!keys_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1(name, keys_valid, 1'b1);
  endtask

  // Monitor: one cycle after each request, compare the registered response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk1("rk_valid", rk_valid, e.v);
        chk1("rk_err", rk_err, e.e);
        chkb("rk_out", rk_out, e.d);
      end else if (rk_valid || rk_err) begin
        total_cnt++;
        $display("FAIL unexpected_response: got valid=%b err=%b expected none", rk_valid, rk_err);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rk_req    = 1'b0;
    rk_idx    = '0;
    model_out = '0;
    repeat (3) @(negedge clk);
    chk1("rst_key_ready", key_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_keys_valid", keys_valid, 1'b0);
    chkb("rst_rk_out", rk_out, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read before any key is loaded.
    rd(4'd0, 1'b0, '0);

    // FIPS-197 key: key_ready low for 10 cycles, with a read and a stray key offer mid-expansion.
    load(K_FIPS);
    for (int i = 0; i < 10; i++) begin
      chk1("exp_key_ready", key_ready, 1'b0);
      chk1("exp_keys_valid", keys_valid, 1'b0);
      if (i == 0) chk1("exp_busy", busy, 1'b1);
      if (i == 2) begin
        rd(4'd3, 1'b0, '0);
      end else begin
        if (i == 3) begin key_in = K_JUNK; key_valid = 1'b1; end
        if (i == 4) key_valid = 1'b0;
        @(negedge clk);
      end
    end
    chk1("done_key_ready", key_ready, 1'b1);
    chk1("done_keys_valid", keys_valid, 1'b1);
    chk1("done_busy", busy, 1'b0);
    key_in = '0;

`ifdef AES_KEYSCHED_BULK_EN
    begin
      block_t t;
      t = rk_all[15:0];
      chkb("bulk_round1", t, F_R1);
      t = rk_all[159:144];
      chkb("bulk_round10", t, F_R10);
    end
`endif

    rd(4'd1, 1'b1, F_R1);
    rd(4'd10, 1'b1, F_R10);
    rd(4'd0, 1'b1, K_FIPS);
    rd(4'd11, 1'b0, '0);
    rd(4'd2, 1'b1, F_R2);
    rd(4'd15, 1'b0, '0);

    // New all-zero key accepted on the same edge as a read of the old schedule.
    key_in    = K_ZERO;
    key_valid = 1'b1;
    rd(4'd10, 1'b1, F_R10);
    key_valid = 1'b0;
    rd(4'd1, 1'b0, '0);
    wait_keys("zero_keys_valid");
    rd(4'd10, 1'b1, Z_R10);
    rd(4'd1, 1'b1, Z_R1);
    rd(4'd0, 1'b1, K_ZERO);

    // Reset in the middle of expansion.
    load(K_FIPS);
    repeat (4) @(negedge clk);
    chk1("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_key_ready", key_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_keys_valid", keys_valid, 1'b0);
    chk1("abort_rk_valid", rk_valid, 1'b0);
    chk1("abort_rk_err", rk_err, 1'b0);
    chkb("abort_rk_out", rk_out, '0);
    model_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd0, 1'b0, '0);
    repeat (12) @(negedge clk);
    chk1("post_abort_keys_valid", keys_valid, 1'b0);
    rd(4'd5, 1'b0, '0);

    // Fresh expansion after the abort.
    load(K_FIPS);
    wait_keys("reload_keys_valid");
    rd(4'd10, 1'b1, F_R10);
    rd(4'd1, 1'b1, F_R1);

    repeat (3) @(negedge clk);
    total_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential AES-128 round-key scheduler. It accepts one 128-bit cipher key and iterates a single-round expansion unit ten times, one round per cycle, storing keys 0..10 in a register file. It then serves round keys by index to the encrypt/decrypt round datapath. It replaces the fully unrolled whole-schedule expander with a reusable controller that has a load handshake and a registered read port.

## Interface
Parameters:
- NUM_ROUNDS, 10: number of expanded round keys; the stored key count is NUM_ROUNDS+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  [15:0][7:0]  cipher key; byte 15 is the first FIPS-197 byte
- key_valid  in  1  key offer
- key_ready  out  1  scheduler can accept a key
- busy  out  1  expansion in progress
- keys_valid  out  1  all 11 round keys are stored and consistent
- rk_req  in  1  round-key read request
- rk_idx  in  4  round-key index, 0..10
- rk_out  out  [15:0][7:0]  registered round key, same byte order as key_in
- rk_valid  out  1  rk_out holds the requested key
- rk_err  out  1  the request was rejected

## Operation
- FSM states:
  - IDLE: key_ready=1. A key_valid&&key_ready edge writes key_in to slot 0, sets round=1, and moves to EXPAND.
  - EXPAND: busy=1, key_ready=0. Each cycle, slot[round] = key_round(slot[round-1], RCON[round]) and round increments. On the round==10 write, the FSM moves to READY, sets keys_valid=1, and clears round to 0.
  - READY: key_ready=1, keys_valid=1. A new key acceptance overwrites slot 0, clears keys_valid at the same edge, and moves to EXPAND.
- key_round: w0'=w0^SubWord(RotWord(w3))^{RCON,0,0,0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. w0 is bytes 15..12.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Reads:
  - rk_req with keys_valid=1 and rk_idx<=10: the next edge sets rk_out=slot[rk_idx] and rk_valid=1.
  - rk_req with keys_valid=0 or rk_idx>10: the next edge sets rk_valid=0, rk_err=1, and leaves rk_out unchanged.
  - No rk_req: rk_valid=0 and rk_err=0 on the next edge; rk_out holds its value.
- Simultaneous read and new-key acceptance in READY: keys_valid is still 1 at that edge, so the read is serviced from the storage values before the edge (old key schedule). Subsequent reads return rk_err until the new expansion completes.
- key_valid during EXPAND is ignored; the offer must be held until key_ready.
- Reset (asynchronous, any state): FSM=IDLE, round=0, all slots=0, keys_valid=0, busy=0, rk_out=0, rk_valid=0, rk_err=0. key_ready=1 follows from IDLE.
- Reset mid-EXPAND aborts the expansion. No partial schedule is ever flagged valid.

## Timing
- Key acceptance is at edge E0. Slots 1..10 are written at E1..E10. keys_valid rises at E10 and is visible in the cycle after E10.
- Back-to-back: a key can be accepted at E10+1 at the earliest.
- Read latency is 1 cycle: request in cycle n gives response in cycle n+1. A new request can be issued every cycle.
- key_ready, busy: combinational from the FSM state only. keys_valid, rk_out, rk_valid, rk_err: registered.
- The S-box is combinational inside key_round; the critical path is one S-box plus three XOR levels.

## Configuration
- AES_KEYSCHED_BULK_EN:
  - Defined: adds output rk_all [16*(NUM_ROUNDS)-1:0][7:0]. It carries slots 1..10 flattened, with round r in bytes 16r-1..16(r-1). This is compatible with legacy consumers of the unrolled expander. rk_all is valid only while keys_valid=1 and is 0 after reset.
  - Undefined: the port and its wiring are absent. Behaviour is otherwise identical.

## Structure
- Package aes_pkg contains:
  - byte_t
  - block_t ([15:0][7:0])
  - NUM_ROUNDS
  - RCON array
  - S-box function
  - FSM state enum (IDLE, EXPAND, READY)
- One sub-module, aes_key_round: combinational single-round expansion taking block_t plus the rcon byte. It is instantiated once.

## Test plan
- Reset, then key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> key_ready low for 10 cycles. keys_valid rises 10 cycles after acceptance. Reading idx 1 returns a0fafe17 88542cb1 23a33939 2a6c7605; reading idx 10 returns d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Read idx 0 after expansion -> the original key with rk_valid=1. Read idx 11 -> rk_err=1, rk_valid=0, rk_out unchanged.
- Read during EXPAND (idx 3) -> rk_err=1. A key_valid pulse during EXPAND has no effect on the stored schedule.
- In READY, issue rk_req idx 10 and a new all-zero key at the same edge -> the read returns d014f9a8 c9ee2589 e13f0cc8 b6630ca6. After expansion, idx 10 returns b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- Assert rst_n low at expansion round 5 -> all outputs are 0 and key_ready=1 immediately. A subsequent read returns rk_err=1 until a fresh expansion completes.
- With AES_KEYSCHED_BULK_EN, run the first scenario -> rk_all bytes 15..0 equal the round-1 key and bytes 159..144 equal the round-10 key.
